// File: rtl/xfn_byte_shuttle_pkg.sv
// xfn_byte_shuttle_pkg: shared byte width, FSM encoding and settle range check
package xfn_byte_shuttle_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    XFN_IDLE   = 2'd0,
    XFN_SETTLE = 2'd1,
    XFN_SEND   = 2'd2
  } xfn_state_t;
  function automatic bit settle_ok(input int s);
    return (s >= 1) && (s <= 255);
  endfunction
endpackage

// File: rtl/xfn_settle_timer.sv
// xfn_settle_timer: 8-bit loadable down-counter flagging its final cycle
module xfn_settle_timer
  import xfn_byte_shuttle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_last
);
  logic [BYTE_W-1:0] r_cnt;
  // load wins over decrement so a fresh operand always restarts the full settle time
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en) r_cnt <= r_cnt - 8'd1;
  end
  assign o_last = (r_cnt == 8'd1);
endmodule

// File: rtl/xfn_byte_shuttle.sv
// xfn_byte_shuttle: registers a UART byte into a combinational function and hands the result to the transmitter
module xfn_byte_shuttle
  import xfn_byte_shuttle_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BYTE_W-1:0]  rx_byte,
  input  logic               rx_valid,
  output logic [BYTE_W-1:0]  fn_x,
  input  logic [BYTE_W-1:0]  fn_out,
  output logic [BYTE_W-1:0]  tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overrun,
  input  logic               overrun_clear,
  output logic [COUNT_W-1:0] txn_count
);
  if (!settle_ok(SETTLE_CYCLES)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..255");
  end
  xfn_state_t r_state, w_next;
  logic [BYTE_W-1:0]  r_fn_x, r_tx_byte;
  logic               r_tx_valid, r_overrun;
  logic [COUNT_W-1:0] r_txn;
  logic               w_last, w_accept, w_capture, w_hs, w_drop;
  assign w_accept  = (r_state == XFN_IDLE) && rx_valid;
  assign w_capture = (r_state == XFN_SETTLE) && w_last;
  assign w_hs      = (r_state == XFN_SEND) && r_tx_valid && tx_ready;
  assign w_drop    = (r_state != XFN_IDLE) && rx_valid;
  xfn_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (8'(SETTLE_CYCLES)),
    .i_en       (r_state == XFN_SETTLE),
    .o_last     (w_last)
  );
  // next state; the unused encoding falls back to IDLE
  always_comb begin
    w_next = XFN_IDLE;
    case (r_state)
      XFN_IDLE:   w_next = w_accept  ? XFN_SETTLE : XFN_IDLE;
      XFN_SETTLE: w_next = w_capture ? XFN_SEND   : XFN_SETTLE;
      XFN_SEND:   w_next = w_hs      ? XFN_IDLE   : XFN_SEND;
      default:    w_next = XFN_IDLE;
    endcase
  end
  // state, operand/result registers, sticky overrun (clear dominates) and handshake counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= XFN_IDLE;
      r_fn_x     <= '0;
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_txn      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_fn_x <= rx_byte;
      if (w_capture) r_tx_byte <= fn_out;
      r_tx_valid <= w_capture ? 1'b1 : (w_hs ? 1'b0 : r_tx_valid);
      r_overrun  <= overrun_clear ? 1'b0 : (w_drop ? 1'b1 : r_overrun);
      if (w_hs) r_txn <= r_txn + COUNT_W'(1);
    end
  end
  assign fn_x      = r_fn_x;
  assign tx_byte   = r_tx_byte;
  assign tx_valid  = r_tx_valid;
  assign busy      = (r_state != XFN_IDLE);
  assign overrun   = r_overrun;
  assign txn_count = r_txn;
endmodule

// File: tb/tb_xfn_byte_shuttle.sv
// tb_xfn_byte_shuttle: directed scenarios plus randomized run against a transaction-level model
module tb_xfn_byte_shuttle;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       overrun_clear = 1'b0;
  logic       glitch = 1'b0;
  logic [7:0] fn_x1, fn_out1, tx_byte1, fn_x3, fn_out3, tx_byte3;
  logic       tx_valid1, busy1, overrun1, tx_valid3, busy3, overrun3;
  logic [15:0] txn1;
  logic [3:0]  txn3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign fn_out1 = fn_x1 + 8'd1;
  assign fn_out3 = glitch ? 8'hEE : fn_x3 + 8'd1;

  xfn_byte_shuttle #(.SETTLE_CYCLES(1), .COUNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .fn_x(fn_x1), .fn_out(fn_out1), .tx_byte(tx_byte1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .busy(busy1), .overrun(overrun1),
    .overrun_clear(overrun_clear), .txn_count(txn1));

  xfn_byte_shuttle #(.SETTLE_CYCLES(3), .COUNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .fn_x(fn_x3), .fn_out(fn_out3), .tx_byte(tx_byte3), .tx_valid(tx_valid3),
    .tx_ready(tx_ready), .busy(busy3), .overrun(overrun3),
    .overrun_clear(overrun_clear), .txn_count(txn3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; tx_ready = 1'b0; overrun_clear = 1'b0; glitch = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rx_byte = 8'h5A; rx_valid = 1'b1; tx_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0; rx_valid = 1'b0;
    tick();
    checks++;
    if ({fn_x1, tx_byte1, tx_valid1, busy1, overrun1, txn1} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut1 got fn_x=%h tx_byte=%h tv=%b busy=%b ov=%b txn=%0d want all 0",
               fn_x1, tx_byte1, tx_valid1, busy1, overrun1, txn1);
    end
    checks++;
    if ({fn_x3, tx_byte3, tx_valid3, busy3, overrun3, txn3} !== 23'd0) begin
      errors++;
      $display("FAIL reset_dut3 got fn_x=%h tx_byte=%h tv=%b busy=%b ov=%b txn=%0d want all 0",
               fn_x3, tx_byte3, tx_valid3, busy3, overrun3, txn3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    tx_ready = 1'b1; rx_byte = 8'h41; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (fn_x1 !== 8'h41 || tx_valid1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_e0 got fn_x=%h tv=%b busy=%b want 41 0 1", fn_x1, tx_valid1, busy1);
    end
    tick();
    checks++;
    if (tx_valid1 !== 1'b1 || tx_byte1 !== 8'h42) begin
      errors++;
      $display("FAIL basic_e1 got tv=%b tx_byte=%h want 1 42", tx_valid1, tx_byte1);
    end
    tick();
    checks++;
    if (tx_valid1 !== 1'b0 || txn1 !== 16'd1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_e2 got tv=%b txn=%0d busy=%b want 0 1 0", tx_valid1, txn1, busy1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_ready = 1'b1; rx_byte = 8'hFF; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    checks++;
    if (tx_valid1 !== 1'b1 || tx_byte1 !== 8'h00) begin
      errors++;
      $display("FAIL wrap_byte got tv=%b tx_byte=%h want 1 00", tx_valid1, tx_byte1);
    end
    tick();
    rx_byte = 8'h7F; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (fn_x1 !== 8'h7F || overrun1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got fn_x=%h ov=%b want 7f 0", fn_x1, overrun1);
    end
    tick();
    checks++;
    if (tx_valid1 !== 1'b1 || tx_byte1 !== 8'h80) begin
      errors++;
      $display("FAIL b2b_byte got tv=%b tx_byte=%h want 1 80", tx_valid1, tx_byte1);
    end
    tick();
    checks++;
    if (txn1 !== 16'd2 || tx_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count got txn=%0d tv=%b want 2 0", txn1, tx_valid1);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rx_byte = 8'h10; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_valid1 !== 1'b1 || tx_byte1 !== 8'h11 || busy1 !== 1'b1 || txn1 !== 16'd0) begin
        errors++;
        $display("FAIL stall_%0d got tv=%b tx_byte=%h busy=%b txn=%0d want 1 11 1 0",
                 i, tx_valid1, tx_byte1, busy1, txn1);
      end
      tick();
    end
    tx_ready = 1'b1;
    tick();
    tick(); tick(); tick();
    checks++;
    if (txn1 !== 16'd1 || tx_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got txn=%0d tv=%b busy=%b want 1 0 0", txn1, tx_valid1, busy1);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    rx_byte = 8'h05; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    rx_byte = 8'h09; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (overrun1 !== 1'b1 || fn_x1 !== 8'h05 || tx_byte1 !== 8'h06 || tx_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got ov=%b fn_x=%h tx_byte=%h tv=%b want 1 05 06 1",
               overrun1, fn_x1, tx_byte1, tx_valid1);
    end
    overrun_clear = 1'b1;
    tick();
    checks++;
    if (overrun1 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b want 0", overrun1);
    end
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; overrun_clear = 1'b0;
    checks++;
    if (overrun1 !== 1'b0 || fn_x1 !== 8'h05) begin
      errors++;
      $display("FAIL overrun_coincident got ov=%b fn_x=%h want 0 05", overrun1, fn_x1);
    end
    tx_ready = 1'b1; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (txn1 !== 16'd1 || overrun1 !== 1'b1 || fn_x1 !== 8'h05 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_hs_edge got txn=%0d ov=%b fn_x=%h busy=%b want 1 1 05 0",
               txn1, overrun1, fn_x1, busy1);
    end
  endtask

  task automatic test_settle3();
    do_reset();
    tx_ready = 1'b1; rx_byte = 8'h20; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; glitch = 1'b1;
    tick();
    checks++;
    if (tx_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL settle3_e1 got tv=%b want 0", tx_valid3);
    end
    tick();
    checks++;
    if (tx_valid3 !== 1'b0 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL settle3_e2 got tv=%b busy=%b want 0 1", tx_valid3, busy3);
    end
    glitch = 1'b0;
    tick();
    checks++;
    if (tx_valid3 !== 1'b1 || tx_byte3 !== 8'h21) begin
      errors++;
      $display("FAIL settle3_e3 got tv=%b tx_byte=%h want 1 21", tx_valid3, tx_byte3);
    end
    tick();
    checks++;
    if (txn3 !== 4'd1 || tx_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL settle3_hs got txn=%0d tv=%b want 1 0", txn3, tx_valid3);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tx_ready = 1'b1; rx_byte = 8'h33; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({fn_x3, tx_byte3, tx_valid3, busy3, overrun3, txn3} !== 23'd0) begin
      errors++;
      $display("FAIL midreset_state got fn_x=%h tx_byte=%h tv=%b busy=%b ov=%b txn=%0d want all 0",
               fn_x3, tx_byte3, tx_valid3, busy3, overrun3, txn3);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (tx_valid3 !== 1'b0 || txn3 !== 4'd0) begin
        errors++;
        $display("FAIL midreset_quiet_%0d got tv=%b txn=%0d want 0 0", i, tx_valid3, txn3);
      end
    end
    rx_byte = 8'h00; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (tx_valid3 !== 1'b1 || tx_byte3 !== 8'h01) begin
      errors++;
      $display("FAIL midreset_after got tv=%b tx_byte=%h want 1 01", tx_valid3, tx_byte3);
    end
    tick();
    checks++;
    if (txn3 !== 4'd1) begin
      errors++;
      $display("FAIL midreset_count got txn=%0d want 1", txn3);
    end
  endtask

  task automatic test_random();
    bit         pend[2];
    logic [7:0] opnd[2];
    int         ready_at[2];
    int         done[2];
    bit         ov[2];
    int         settle[2];
    bit         was_pend;
    logic [7:0] g_fnx, g_txb;
    logic       g_tv, g_busy, g_ov;
    int         g_txn;
    do_reset();
    settle[0] = 1; settle[1] = 3;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; opnd[k] = 8'h00; ready_at[k] = 0; done[k] = 0; ov[k] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      rx_byte       = 8'($urandom);
      rx_valid      = ($urandom_range(0, 99) < 35);
      tx_ready      = ($urandom_range(0, 99) < 60);
      overrun_clear = ($urandom_range(0, 99) < 5);
      tick();
      for (int k = 0; k < 2; k++) begin
        was_pend = pend[k];
        if (was_pend) begin
          if (n > ready_at[k] && tx_ready) begin
            pend[k] = 0;
            done[k]++;
          end
        end else if (rx_valid) begin
          pend[k] = 1;
          opnd[k] = rx_byte;
          ready_at[k] = n + settle[k];
        end
        ov[k] = overrun_clear ? 1'b0 : ((was_pend && rx_valid) ? 1'b1 : ov[k]);
        g_fnx  = k ? fn_x3 : fn_x1;
        g_txb  = k ? tx_byte3 : tx_byte1;
        g_tv   = k ? tx_valid3 : tx_valid1;
        g_busy = k ? busy3 : busy1;
        g_ov   = k ? overrun3 : overrun1;
        g_txn  = k ? int'(txn3) : int'(txn1);
        checks++;
        if (g_fnx !== opnd[k] || g_tv !== (pend[k] && n >= ready_at[k]) ||
            (g_tv === 1'b1 && g_txb !== opnd[k] + 8'd1) || g_busy !== pend[k] ||
            g_ov !== ov[k] || g_txn != (k ? done[k] % 16 : done[k] % 65536)) begin
          errors++;
          $display("FAIL random_s%0d_cyc%0d got fn_x=%h tv=%b tx_byte=%h busy=%b ov=%b txn=%0d want fn_x=%h tv=%b tx_byte=%h busy=%b ov=%b txn=%0d",
                   settle[k], n, g_fnx, g_tv, g_txb, g_busy, g_ov, g_txn,
                   opnd[k], (pend[k] && n >= ready_at[k]), opnd[k] + 8'd1, pend[k], ov[k],
                   k ? done[k] % 16 : done[k] % 65536);
        end
      end
    end
    rx_valid = 1'b0; overrun_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_overrun();
    test_settle3();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
